// File: rtl/apu_pkg.sv
// apu_pkg: shared frame-sequencer step defaults, wrap points and mode type
package apu_pkg;
  localparam int STEP1_DEF = 7457;
  localparam int STEP2_DEF = 14913;
  localparam int STEP3_DEF = 22371;
  localparam int STEP4_DEF = 29829;
  localparam int STEP5_DEF = 37281;
  localparam int WRAP4_DEF = STEP4_DEF + 1;
  localparam int WRAP5_DEF = STEP5_DEF + 1;
  localparam int WRITE_DELAY_DEF = 3;
  typedef enum logic {MODE_4STEP = 1'b0, MODE_5STEP = 1'b1} mode_e;
endpackage

// File: rtl/apu_frame_counter_if.sv
// apu_frame_counter_if: $4017 write, status ack and frame strobe bundle
interface apu_frame_counter_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       irq_ack;
  logic       quarter_frame;
  logic       half_frame;
  logic       irq;
  modport master (output wr_en, wr_data, irq_ack, input quarter_frame, half_frame, irq);
  modport slave (input wr_en, wr_data, irq_ack, output quarter_frame, half_frame, irq);
endinterface

// File: rtl/frame_step_decode.sv
// frame_step_decode: matches the cycle counter against the step table of the current mode
module frame_step_decode import apu_pkg::*; #(
  parameter int STEP1 = STEP1_DEF,
  parameter int STEP2 = STEP2_DEF,
  parameter int STEP3 = STEP3_DEF,
  parameter int STEP4 = STEP4_DEF,
  parameter int STEP5 = STEP5_DEF
) (
  input  logic [15:0] cnt,
  input  mode_e       mode,
  output logic        q_hit,
  output logic        h_hit,
  output logic        irq_hit,
  output logic        wrap
);
  logic last;
  always_comb begin
    last = mode == MODE_5STEP ? cnt == 16'(STEP5) : cnt == 16'(STEP4);
    q_hit = cnt == 16'(STEP1) || cnt == 16'(STEP2) || cnt == 16'(STEP3) || last;
    h_hit = cnt == 16'(STEP2) || last;
    irq_hit = mode == MODE_4STEP && (cnt == 16'(STEP4 - 1) || cnt == 16'(STEP4) || cnt == 16'(STEP4 + 1));
    wrap = cnt == (mode == MODE_5STEP ? 16'(STEP5 + 1) : 16'(STEP4 + 1));
  end
endmodule

// File: rtl/apu_frame_counter.sv
// apu_frame_counter: APU frame sequencer producing quarter/half-frame strobes and the frame IRQ
module apu_frame_counter import apu_pkg::*; #(
  parameter int STEP1 = STEP1_DEF,
  parameter int STEP2 = STEP2_DEF,
  parameter int STEP3 = STEP3_DEF,
  parameter int STEP4 = STEP4_DEF,
  parameter int STEP5 = STEP5_DEF,
  parameter int WRITE_DELAY = WRITE_DELAY_DEF
) (
  input logic clk,
  input logic rst_n,
  apu_frame_counter_if.slave bus
);
  logic [15:0] cnt;
  mode_e       mode;
  logic        inhibit;
  logic        pending;
  logic [1:0]  dly;
  logic        q_hit, h_hit, irq_hit, wrap, expire;
  logic        unused_wr;
  assign unused_wr = ^bus.wr_data[5:0];
  frame_step_decode #(
    .STEP1(STEP1), .STEP2(STEP2), .STEP3(STEP3), .STEP4(STEP4), .STEP5(STEP5)
  ) u_dec (
    .cnt(cnt), .mode(mode), .q_hit(q_hit), .h_hit(h_hit), .irq_hit(irq_hit), .wrap(wrap)
  );
  // a fresh write on the expiry edge restarts the delay instead of resetting
  assign expire = pending && dly == 2'd1 && !bus.wr_en;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      mode <= MODE_4STEP;
      inhibit <= 1'b0;
      pending <= 1'b0;
      dly <= '0;
      bus.quarter_frame <= 1'b0;
      bus.half_frame <= 1'b0;
      bus.irq <= 1'b0;
    end else begin
      cnt <= (expire || wrap) ? '0 : cnt + 16'd1;
      bus.quarter_frame <= expire ? mode == MODE_5STEP : q_hit;
      bus.half_frame <= expire ? mode == MODE_5STEP : h_hit;
      bus.irq <= (bus.wr_en && bus.wr_data[6]) ? 1'b0 :
                 (irq_hit && !inhibit)         ? 1'b1 :
                 bus.irq_ack                   ? 1'b0 : bus.irq;
      if (bus.wr_en) begin
        mode <= mode_e'(bus.wr_data[7]);
        inhibit <= bus.wr_data[6];
        dly <= 2'(WRITE_DELAY);
        pending <= 1'b1;
      end else if (pending) begin
        dly <= dly - 2'd1;
        pending <= !expire;
      end
    end
  end
endmodule

// File: tb/tb_apu_frame_counter.sv
// tb_apu_frame_counter: directed scenarios plus random writes/acks against a frame-position model
module tb_apu_frame_counter;
  localparam int S1 = 37, S2 = 73, S3 = 111, S4 = 149, S5 = 185, WD = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  apu_frame_counter_if bus();
  apu_frame_counter #(
    .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5), .WRITE_DELAY(WD)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int m_pos, m_q, m_h, m_irq, m_mode, m_inh;
  longint cyc, pend_at;
  int n, nq, nh, nirq, first_q;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_q = 0; m_h = 0; m_irq = 0; m_mode = 0; m_inh = 0;
    cyc = 0; pend_at = -1;
  endtask

  // frame position advances once per clock; a write schedules a position reset WD clocks later
  task automatic model_edge(input logic w, input logic [7:0] d, input logic a);
    int last;
    bit expire, win;
    last = m_mode ? S5 : S4;
    expire = pend_at == cyc && !w;
    win = !m_mode && !m_inh && m_pos >= S4 - 1 && m_pos <= S4 + 1;
    m_q = expire ? m_mode : int'(m_pos == S1 || m_pos == S2 || m_pos == S3 || m_pos == last);
    m_h = expire ? m_mode : int'(m_pos == S2 || m_pos == last);
    m_irq = (w && d[6]) ? 0 : win ? 1 : a ? 0 : m_irq;
    m_pos = (expire || m_pos == last + 1) ? 0 : (m_pos + 1) % 65536;
    if (w) begin
      m_mode = int'(d[7]);
      m_inh = int'(d[6]);
      pend_at = cyc + WD;
    end
    cyc++;
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic a);
    bus.wr_en = w; bus.wr_data = d; bus.irq_ack = a;
    @(posedge clk);
    model_edge(w, d, a);
    #1;
    bus.wr_en = 1'b0; bus.irq_ack = 1'b0;
    n++;
    check("quarter", int'(bus.quarter_frame), m_q);
    check("half", int'(bus.half_frame), m_h);
    check("irq", int'(bus.irq), m_irq);
    nq += int'(bus.quarter_frame);
    nh += int'(bus.half_frame);
    nirq += int'(bus.irq);
    if (bus.quarter_frame && first_q == 0) first_q = n;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic clr();
    n = 0; nq = 0; nh = 0; nirq = 0; first_q = 0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.irq_ack = 1'b0;
    model_reset();
    clr();
    repeat (3) @(posedge clk);
    #1;
    check("rst_quarter", int'(bus.quarter_frame), 0);
    check("rst_half", int'(bus.half_frame), 0);
    check("rst_irq", int'(bus.irq), 0);
    @(negedge clk) rst_n = 1'b1;

    idle(S4 + 2);
    check("frame4_q_count", nq, 4);
    check("frame4_h_count", nh, 2);
    check("frame4_first_q", first_q, S1 + 1);
    check("frame4_irq_high", int'(bus.irq), 1);

    step(1'b0, 8'h00, 1'b1);
    check("ack_irq_low", int'(bus.irq), 0);
    idle(S4 - 2);
    check("ack_irq_still_low", int'(bus.irq), 0);
    idle(1);
    check("irq_reassert", int'(bus.irq), 1);
    idle(2);

    clr();
    step(1'b1, 8'h40, 1'b0);
    check("inhibit_clears_irq", int'(bus.irq), 0);
    idle(WD - 1);
    clr();
    idle(S4 + 2);
    check("inhibit_no_irq", nirq, 0);
    check("inhibit_q_count", nq, 4);

    idle($urandom_range(1, 20));
    clr();
    step(1'b1, 8'h80, 1'b0);
    idle(WD);
    check("forced_q_delay", first_q, WD + 1);
    check("forced_h", int'(bus.half_frame), 1);
    clr();
    idle(S5 + 2);
    check("frame5_q_count", nq, 4);
    check("frame5_h_count", nh, 2);
    check("frame5_no_irq", nirq, 0);

    clr();
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    idle(WD + 3);
    check("b2b_single_q", nq, 1);
    check("b2b_single_h", nh, 1);
    check("b2b_q_delay", first_q, 2 + WD);

    step(1'b1, 8'h00, 1'b0);
    idle(S4 + WD);
    check("pre_reset_irq", int'(bus.irq), 1);
    step(1'b1, 8'h80, 1'b0);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_quarter", int'(bus.quarter_frame), 0);
    check("async_rst_half", int'(bus.half_frame), 0);
    check("async_rst_irq", int'(bus.irq), 0);
    @(negedge clk) rst_n = 1'b1;
    clr();
    idle(S1 + 2);
    check("post_reset_q_count", nq, 1);
    check("post_reset_first_q", first_q, S1 + 1);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 63) == 0, 8'($urandom), $urandom_range(0, 15) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
